// File: rtl/vin_pkg.sv
// ---------------------------------------------------------------------------
// vin_pkg -- shared constants for the video test-pattern generator.
//   mode_e      : pattern select encodings carried on the 3-bit mode port.
//   state_e     : timing FSM states.
//   CFG_*       : field indices inside the packed {sync, bp, act, fp} timing
//                 words; field f occupies bits [cfg_lsb(f,TW) +: TW].
// ---------------------------------------------------------------------------
package vin_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID   = 3'd0,
        MODE_HRAMP   = 3'd1,
        MODE_VRAMP   = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_BAR     = 3'd4,
        MODE_FILL    = 3'd5
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Packed order is {sync, bp, act, fp} with sync in the MSBs.
    localparam int CFG_FP     = 0;
    localparam int CFG_ACT    = 1;
    localparam int CFG_BP     = 2;
    localparam int CFG_SYNC   = 3;
    localparam int CFG_FIELDS = 4;

    function automatic int cfg_lsb(input int field, input int tw);
        return field * tw;
    endfunction

endpackage

// File: rtl/vin_timing.sv
// ---------------------------------------------------------------------------
// vin_timing -- run/idle FSM, h/v counters, shadow configuration and the
// raw (unregistered) sync / data-enable decode.
//   clk, rst          : clock and synchronous active-high reset
//   enable            : run request, sampled in IDLE and at frame boundaries
//   mode, solid_level : pattern config, shadowed at latch time
//   cfg_h, cfg_v      : packed {sync, bp, act, fp} timing words
//   hsync, vsync, de  : active-high raw decode of the current counter state
//   frame_first       : counter state is h=0, v=0 while running
//   x, y              : active-region coordinates (valid while de=1)
//   frame_count       : completed frames, wraps at 16 bits
//   cur_mode, cur_level : shadowed pattern config
// ---------------------------------------------------------------------------
module vin_timing
    import vin_pkg::*;
#(
    parameter int TW       = 12,
    parameter int PIX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [2:0]          mode,
    input  logic [PIX_BITS-1:0] solid_level,
    input  logic [4*TW-1:0]     cfg_h,
    input  logic [4*TW-1:0]     cfg_v,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                frame_first,
    output logic [TW-1:0]       x,
    output logic [TW-1:0]       y,
    output logic [15:0]         frame_count,
    output logic [2:0]          cur_mode,
    output logic [PIX_BITS-1:0] cur_level
);

    // Two spare bits so the four-field sums never overflow.
    localparam int HW = TW + 2;

    state_e                state_reg;
    logic [HW-1:0]         h_reg;
    logic [HW-1:0]         v_reg;
    logic [15:0]           fc_reg;
    logic [TW-1:0]         sh_h_reg [CFG_FIELDS];
    logic [TW-1:0]         sh_v_reg [CFG_FIELDS];
    logic [2:0]            mode_reg;
    logic [PIX_BITS-1:0]   level_reg;

    logic [TW-1:0]         h_fix [CFG_FIELDS];
    logic [TW-1:0]         v_fix [CFG_FIELDS];
    logic [HW-1:0]         h_de_start, h_de_end, h_total;
    logic [HW-1:0]         v_de_start, v_de_end, v_total;
    logic                  running, h_last, v_last, latch;

    // A zero-length field would make a region vanish; clamp to one.
    for (genvar gi = 0; gi < CFG_FIELDS; gi++) begin : g_fix
        assign h_fix[gi] = (cfg_h[cfg_lsb(gi, TW) +: TW] == '0) ? TW'(1) : cfg_h[cfg_lsb(gi, TW) +: TW];
        assign v_fix[gi] = (cfg_v[cfg_lsb(gi, TW) +: TW] == '0) ? TW'(1) : cfg_v[cfg_lsb(gi, TW) +: TW];
    end

    assign h_de_start = HW'(sh_h_reg[CFG_SYNC]) + HW'(sh_h_reg[CFG_BP]);
    assign h_de_end   = h_de_start + HW'(sh_h_reg[CFG_ACT]);
    assign h_total    = h_de_end + HW'(sh_h_reg[CFG_FP]);
    assign v_de_start = HW'(sh_v_reg[CFG_SYNC]) + HW'(sh_v_reg[CFG_BP]);
    assign v_de_end   = v_de_start + HW'(sh_v_reg[CFG_ACT]);
    assign v_total    = v_de_end + HW'(sh_v_reg[CFG_FP]);

    assign running = (state_reg == ST_RUN);
    assign h_last  = (h_reg == h_total - HW'(1));
    assign v_last  = (v_reg == v_total - HW'(1));
    // Config is only taken when starting from IDLE or on the last cycle of a
    // frame, so a frame never sees a mix of old and new timing.
    assign latch   = enable && (!running || (h_last && v_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            h_reg     <= '0;
            v_reg     <= '0;
            fc_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    h_reg <= '0;
                    v_reg <= '0;
                    if (enable) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (h_last) begin
                        h_reg <= '0;
                        if (v_last) begin
                            v_reg  <= '0;
                            fc_reg <= fc_reg + 16'd1;
                            if (!enable) state_reg <= ST_IDLE;
                        end else begin
                            v_reg <= v_reg + HW'(1);
                        end
                    end else begin
                        h_reg <= h_reg + HW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CFG_FIELDS; i++) begin
                sh_h_reg[i] <= '0;
                sh_v_reg[i] <= '0;
            end
            mode_reg  <= '0;
            level_reg <= '0;
        end else if (latch) begin
            for (int i = 0; i < CFG_FIELDS; i++) begin
                sh_h_reg[i] <= h_fix[i];
                sh_v_reg[i] <= v_fix[i];
            end
            mode_reg  <= mode;
            level_reg <= solid_level;
        end
    end

    assign hsync       = running && (h_reg < HW'(sh_h_reg[CFG_SYNC]));
    assign vsync       = running && (v_reg < HW'(sh_v_reg[CFG_SYNC]));
    assign de          = running && (h_reg >= h_de_start) && (h_reg < h_de_end)
                                 && (v_reg >= v_de_start) && (v_reg < v_de_end);
    assign frame_first = running && (h_reg == '0) && (v_reg == '0);
    // Only meaningful inside the active window; the pattern is masked elsewhere.
    assign x           = h_reg[TW-1:0] - h_de_start[TW-1:0];
    assign y           = v_reg[TW-1:0] - v_de_start[TW-1:0];
    assign frame_count = fc_reg;
    assign cur_mode    = mode_reg;
    assign cur_level   = level_reg;

endmodule

// File: rtl/vin_testgen.sv
// ---------------------------------------------------------------------------
// vin_testgen -- video timing and test-pattern generator.
//   clk, rst            : clock and synchronous active-high reset
//   enable              : run request
//   mode                : 0 solid, 1 h-ramp, 2 v-ramp, 3 checker, 4 bar,
//                         5 frame fill, 6-7 solid
//   solid_level         : level for the solid pattern
//   cfg_h, cfg_v        : {sync, bp, act, fp} in clocks / lines
//   v_vsync, v_hsync    : syncs, active level SYNC_POL
//   v_de, v_pixel       : data enable and PPC pixels (lane 0 in LSBs)
//   frame_start         : pulse on the first output cycle of each frame
//   frame_count         : completed-frame counter
// All outputs are registered one cycle behind the timing counters.
// ---------------------------------------------------------------------------
module vin_testgen
    import vin_pkg::*;
#(
    parameter int PIX_BITS = 8,
    parameter int PPC      = 2,
    parameter int TW       = 12,
    parameter int SYNC_POL = 0,
    parameter int BAR_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [2:0]              mode,
    input  logic [PIX_BITS-1:0]     solid_level,
    input  logic [4*TW-1:0]         cfg_h,
    input  logic [4*TW-1:0]         cfg_v,
    output logic                    v_vsync,
    output logic                    v_hsync,
    output logic                    v_de,
    output logic [PPC*PIX_BITS-1:0] v_pixel,
    output logic                    frame_start,
    output logic [15:0]             frame_count
);

    localparam logic SYNC_ACT = (SYNC_POL != 0);
    localparam int   BW       = TW - BAR_LOG2;

    logic                    hsync, vsync, de, frame_first;
    logic [TW-1:0]           x, y;
    logic [15:0]             fc;
    logic [2:0]              cur_mode;
    logic [PIX_BITS-1:0]     cur_level;
    logic [PPC*PIX_BITS-1:0] pix_next;

    logic                    vsync_reg, hsync_reg, de_reg, fs_reg;
    logic [PPC*PIX_BITS-1:0] pixel_reg;
    logic [15:0]             fc_reg;

    vin_timing #(
        .TW       (TW),
        .PIX_BITS (PIX_BITS)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .solid_level (solid_level),
        .cfg_h       (cfg_h),
        .cfg_v       (cfg_v),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_first (frame_first),
        .x           (x),
        .y           (y),
        .frame_count (fc),
        .cur_mode    (cur_mode),
        .cur_level   (cur_level)
    );

    for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
        logic [PIX_BITS-1:0] lane;
        always_comb begin
            lane = cur_level;
            case (cur_mode)
                MODE_HRAMP:   lane = PIX_BITS'(x * PPC + gi);
                MODE_VRAMP:   lane = PIX_BITS'(y);
                MODE_CHECKER: lane = (x[BAR_LOG2] ^ y[BAR_LOG2]) ? '1 : '0;
                // The bar walks one cell to the right every frame.
                MODE_BAR:     lane = (x[TW-1:BAR_LOG2] == BW'(fc)) ? '1 : '0;
                MODE_FILL:    lane = PIX_BITS'(fc);
                default:      lane = cur_level;
            endcase
        end
        assign pix_next[gi*PIX_BITS +: PIX_BITS] = lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_reg <= ~SYNC_ACT;
            hsync_reg <= ~SYNC_ACT;
            de_reg    <= 1'b0;
            pixel_reg <= '0;
            fs_reg    <= 1'b0;
            fc_reg    <= '0;
        end else begin
            vsync_reg <= vsync ? SYNC_ACT : ~SYNC_ACT;
            hsync_reg <= hsync ? SYNC_ACT : ~SYNC_ACT;
            de_reg    <= de;
            pixel_reg <= de ? pix_next : '0;
            fs_reg    <= frame_first;
            fc_reg    <= fc;
        end
    end

    assign v_vsync     = vsync_reg;
    assign v_hsync     = hsync_reg;
    assign v_de        = de_reg;
    assign v_pixel     = pixel_reg;
    assign frame_start = fs_reg;
    assign frame_count = fc_reg;

endmodule
